// File: rtl/gomoku_pkg.sv
// gomoku_pkg: board defaults, cell codes, line directions and scheduler states
package gomoku_pkg;
    localparam int DEF_BOARD_N = 15;
    localparam int DEF_WIN_LEN = 5;
    typedef enum logic [1:0] {
        CELL_EMPTY = 2'b00,
        CELL_BLACK = 2'b01,
        CELL_WHITE = 2'b10
    } cell_t;
    // Row/col deltas in scan order: horizontal, vertical, diagonal, anti-diagonal
    localparam logic signed [1:0] DIR_DR [4] = '{2'sd0, 2'sd1, 2'sd1, 2'sd1};
    localparam logic signed [1:0] DIR_DC [4] = '{2'sd1, 2'sd0, 2'sd1, -2'sd1};
    typedef enum logic [1:0] {IDLE, SCAN, FINISH} sched_state_t;
endpackage

// File: rtl/win_scan_stepper.sv
// win_scan_stepper: maps (base, direction, step) to a board cell and registers the issue tag
// so it lines up with the board memory's one-cycle read latency
module win_scan_stepper
    import gomoku_pkg::*;
#(
    parameter int BOARD_N = DEF_BOARD_N,
    parameter int WIN_LEN = DEF_WIN_LEN,
    parameter int COORD_W = 4,
    parameter int ADDR_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    issue,
    input  logic [COORD_W-1:0]      base_row,
    input  logic [COORD_W-1:0]      base_col,
    input  logic [1:0]              dir,
    input  logic signed [COORD_W:0] k,
    output logic                    in_bounds,
    output logic [ADDR_W-1:0]       addr,
    output logic                    tag_valid,
    output logic                    tag_in_bounds,
    output logic                    tag_first,
    output logic                    tag_last
);
    localparam logic signed [COORD_W:0] K_MAX = (COORD_W+1)'(WIN_LEN - 1);
    localparam logic [COORD_W:0] EDGE = (COORD_W+1)'(BOARD_N);
    logic signed [COORD_W:0] r, c;
    always_comb begin
        r = $signed({1'b0, base_row}) + k * (COORD_W+1)'(DIR_DR[dir]);
        c = $signed({1'b0, base_col}) + k * (COORD_W+1)'(DIR_DC[dir]);
        in_bounds = !r[COORD_W] && !c[COORD_W] && $unsigned(r) < EDGE && $unsigned(c) < EDGE;
        addr = (issue && in_bounds)
            ? ADDR_W'(r[COORD_W-1:0]) * ADDR_W'(BOARD_N) + ADDR_W'(c[COORD_W-1:0]) : '0;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {tag_valid, tag_in_bounds, tag_first, tag_last} <= '0;
        end else begin
            tag_valid     <= issue;
            tag_in_bounds <= issue && in_bounds;
            tag_first     <= k == -K_MAX;
            tag_last      <= dir == 2'd3 && k == K_MAX;
        end
    end
endmodule

// File: rtl/win_check_scheduler.sv
// win_check_scheduler: after each move walks the four lines through the placed stone and
// reports win, no-win or draw; sole owner of the board read port while busy
module win_check_scheduler
    import gomoku_pkg::*;
#(
    parameter int BOARD_N = DEF_BOARD_N,
    parameter int WIN_LEN = DEF_WIN_LEN,
    parameter int COORD_W = 4,
    parameter int ADDR_W  = 8
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic               start,
    input  logic [COORD_W-1:0] row,
    input  logic [COORD_W-1:0] col,
    input  logic               player,
    input  logic               new_game,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               mem_rd,
    input  logic [1:0]         mem_data,
    output logic               busy,
    output logic               done,
    output logic               win,
    output logic               draw,
    output logic               winner
);
    localparam int RUN_W  = $clog2(WIN_LEN + 1);
    localparam int MOVE_W = $clog2(BOARD_N * BOARD_N + 1);
    localparam logic [MOVE_W-1:0] FULL = MOVE_W'(BOARD_N * BOARD_N);
    localparam logic signed [COORD_W:0] K_MAX = (COORD_W+1)'(WIN_LEN - 1);
    localparam logic signed [COORD_W:0] K_ONE = (COORD_W+1)'(1);

    sched_state_t            state;
    logic [COORD_W-1:0]      row_q, col_q;
    logic                    player_q, issuing, in_bounds, hit;
    logic                    tag_valid, tag_in_bounds, tag_first, tag_last;
    logic [1:0]              dir;
    logic signed [COORD_W:0] k;
    logic [RUN_W-1:0]        run, run_next;
    logic [MOVE_W-1:0]       moves;

    win_scan_stepper #(
        .BOARD_N(BOARD_N), .WIN_LEN(WIN_LEN), .COORD_W(COORD_W), .ADDR_W(ADDR_W)
    ) u_stepper (
        .clk(CLOCK_50), .rst_n(reset), .issue(issuing), .base_row(row_q), .base_col(col_q),
        .dir(dir), .k(k), .in_bounds(in_bounds), .addr(mem_addr), .tag_valid(tag_valid),
        .tag_in_bounds(tag_in_bounds), .tag_first(tag_first), .tag_last(tag_last)
    );

    // Out-of-board issues carry tag_in_bounds=0, so they break a run like an empty cell
    always_comb begin
        mem_rd   = issuing && in_bounds;
        run_next = (tag_in_bounds && mem_data == (player_q ? CELL_WHITE : CELL_BLACK))
            ? (tag_first ? '0 : run) + RUN_W'(1) : '0;
        hit      = state == SCAN && tag_valid && run_next >= RUN_W'(WIN_LEN);
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            {busy, done, win, draw, winner, player_q, issuing} <= '0;
            row_q <= '0;
            col_q <= '0;
            dir   <= '0;
            k     <= '0;
            run   <= '0;
            moves <= '0;
        end else if (new_game) begin
            state <= IDLE;
            {busy, done, win, draw, winner, issuing} <= '0;
            moves <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    row_q    <= row;
                    col_q    <= col;
                    player_q <= player;
                    dir      <= '0;
                    k        <= -K_MAX;
                    issuing  <= 1'b1;
                    busy     <= 1'b1;
                    moves    <= (moves == FULL) ? moves : moves + MOVE_W'(1);
                    state    <= SCAN;
                end
                SCAN: begin
                    if (tag_valid) run <= run_next;
                    if (issuing) begin
                        k       <= (k == K_MAX) ? -K_MAX : k + K_ONE;
                        dir     <= (k == K_MAX) ? dir + 2'd1 : dir;
                        issuing <= !(k == K_MAX && dir == 2'd3);
                    end
                    if (hit || (tag_valid && tag_last)) begin
                        state   <= FINISH;
                        issuing <= 1'b0;
                        done    <= 1'b1;
                        win     <= hit;
                        winner  <= hit ? player_q : winner;
                        draw    <= draw || (!hit && moves == FULL);
                    end
                end
                FINISH: begin
                    state <= IDLE;
                    {busy, done, win} <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_win_check_scheduler.sv
// tb_win_check_scheduler: directed vectors against a registered board-memory model
module tb_win_check_scheduler;
    localparam int N = 15;

    typedef struct {
        int lr, lc, ldr, ldc, ln, lcode;
        int xr, xc, xcode;
        int sr, sc, p, pulse;
        int done, win, rds, addr1;
    } vec_t;

    logic       clk = 0, rst_n = 0, start = 0, player = 0, new_game = 0;
    logic [3:0] row = 0, col = 0;
    logic [7:0] mem_addr;
    logic       mem_rd;
    logic [1:0] mem_data;
    logic       busy, done, win, draw, winner;
    logic [1:0] board [N*N];
    int         checks = 0, errors = 0, exp_winner = 0;
    vec_t       vecs [9];

    win_check_scheduler dut (
        .CLOCK_50(clk), .reset(rst_n), .start(start), .row(row), .col(col), .player(player),
        .new_game(new_game), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
        .busy(busy), .done(done), .win(win), .draw(draw), .winner(winner)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        mem_data <= (mem_rd && mem_addr < 8'(N*N)) ? board[mem_addr] : 2'b00;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_board();
        foreach (board[i]) board[i] = 2'b00;
    endtask

    task automatic put(input int r, input int c, input int code);
        board[r*N+c] = 2'(code);
    endtask

    task automatic count_done(input int n, output int dn);
        dn = 0;
        repeat (n) begin
            @(negedge clk);
            if (done) dn++;
        end
    endtask

    task automatic pulse_new_game();
        @(negedge clk); new_game = 1;
        @(negedge clk); new_game = 0;
    endtask

    // Cycle n is the n-th cycle after the edge that samples start; outputs sampled at negedge
    task automatic do_move(input int sr, input int sc, input int p, input int pulse,
                           output int dc, output int w, output int d, output int rdc,
                           output int lrd, output int a1, output int blo, output int bad);
        @(negedge clk); row = 4'(sr); col = 4'(sc); player = p[0]; start = 1;
        @(negedge clk); start = 0;
        dc = 0; w = 0; d = 0; rdc = 0; lrd = 0; a1 = -1; blo = 0; bad = 0;
        for (int n = 1; n <= 60; n++) begin
            if (n > 1) @(negedge clk);
            start = (n == pulse);
            if (n == pulse) begin row = 0; col = 0; player = ~p[0]; end
            if (mem_rd) begin
                rdc++;
                lrd = n;
                if (n == 1) a1 = int'(mem_addr);
                if (mem_addr >= 8'(N*N)) bad++;
            end
            if (!busy) blo++;
            if (done) begin
                dc = n; w = int'(win); d = int'(draw);
                break;
            end
        end
        @(negedge clk); start = 0;
        if (busy || done) blo++;
    endtask

    task automatic play_round(input int last_win);
        int dc, w, d, rdc, lrd, a1, blo, bad, last;
        for (int i = 0; i < N*N; i++) begin
            last = int'(i == N*N-1);
            clear_board();
            if (last != 0 && last_win != 0) for (int j = 0; j < 5; j++) put(14, 10 + j, 1);
            else board[i] = 2'b01;
            do_move(i / N, i % N, 0, (i == 0) ? 10 : 0, dc, w, d, rdc, lrd, a1, blo, bad);
            check($sformatf("move%0d_done_cycle", i), dc, (last != 0 && last_win != 0) ? 7 : 38);
            check($sformatf("move%0d_win", i), w, last & last_win);
            check($sformatf("move%0d_draw", i), d, last & ~last_win & 1);
        end
    endtask

    initial begin
        int dc, w, d, rdc, lrd, a1, blo, bad, dn;
        vecs = '{
            '{7, 3, 0, 1, 5, 1,   0, 0, 0,   7, 7, 0, 0,    7, 1, -1, 108},
            '{7, 3, 0, 1, 4, 1,   7, 7, 2,   7, 6, 0, 0,   38, 0, -1, 107},
            '{7, 8, 0, 1, 4, 1,   3, 7, 1,   7, 7, 0, 0,   38, 0, -1, 108},
            '{2, 0, 0, 1, 5, 1,   0, 0, 0,   2, 4, 1, 0,   38, 0, -1, 30},
            '{5, 0, 0, 1, 5, 3,   0, 0, 0,   5, 2, 1, 0,   38, 0, -1, -1},
            '{5, 0, 0, 1, 5, 3,   0, 0, 0,   5, 4, 0, 0,   38, 0, -1, 75},
            '{10, 2, 1, 0, 5, 1,  0, 0, 0,  12, 2, 0, 0,   18, 1, -1, -1},
            '{0, 0, 1, 1, 5, 2,   0, 0, 0,   0, 0, 1, 0,   29, 1, 15, -1},
            '{0, 14, 1, -1, 5, 2, 0, 0, 0,   4, 10, 1, 10, 34, 1, -1, 66}
        };
        clear_board();
        repeat (2) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_win", win, 0);
        check("reset_draw", draw, 0);
        check("reset_winner", winner, 0);
        check("reset_mem_rd", mem_rd, 0);
        check("reset_mem_addr", mem_addr, 0);
        rst_n = 1;

        for (int i = 0; i < 9; i++) begin
            clear_board();
            for (int j = 0; j < vecs[i].ln; j++)
                put(vecs[i].lr + j*vecs[i].ldr, vecs[i].lc + j*vecs[i].ldc, vecs[i].lcode);
            if (vecs[i].xcode != 0) put(vecs[i].xr, vecs[i].xc, vecs[i].xcode);
            do_move(vecs[i].sr, vecs[i].sc, vecs[i].p, vecs[i].pulse, dc, w, d, rdc, lrd, a1, blo, bad);
            if (vecs[i].win != 0) exp_winner = vecs[i].p;
            check($sformatf("v%0d_done_cycle", i), dc, vecs[i].done);
            check($sformatf("v%0d_win", i), w, vecs[i].win);
            check($sformatf("v%0d_draw", i), d, 0);
            check($sformatf("v%0d_winner", i), winner, exp_winner);
            check($sformatf("v%0d_first_addr", i), a1, vecs[i].addr1);
            check($sformatf("v%0d_busy_window", i), blo, 0);
            check($sformatf("v%0d_addr_in_board", i), bad, 0);
            check($sformatf("v%0d_last_rd_ok", i),
                  int'(lrd <= vecs[i].done - ((vecs[i].win != 0) ? 1 : 2)), 1);
            if (vecs[i].rds >= 0) check($sformatf("v%0d_rd_count", i), rdc, vecs[i].rds);
        end

        clear_board(); put(7, 7, 1);
        @(negedge clk); row = 7; col = 7; player = 0; start = 1;
        @(negedge clk); start = 0;
        repeat (9) @(negedge clk);
        rst_n = 0;
        #1;
        exp_winner = 0;
        check("midscan_reset_busy", busy, 0);
        check("midscan_reset_done", done, 0);
        check("midscan_reset_win", win, 0);
        check("midscan_reset_winner", winner, exp_winner);
        check("midscan_reset_mem_rd", mem_rd, 0);
        check("midscan_reset_mem_addr", mem_addr, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        count_done(45, dn);
        check("midscan_reset_no_done", dn, 0);

        clear_board();
        for (int j = 0; j < 5; j++) put(j, 14 - j, 2);
        do_move(4, 10, 1, 0, dc, w, d, rdc, lrd, a1, blo, bad);
        exp_winner = 1;
        check("pre_newgame_win", w, 1);
        check("pre_newgame_winner", winner, exp_winner);
        @(negedge clk); row = 7; col = 7; player = 0; start = 1;
        @(negedge clk); start = 0;
        repeat (9) @(negedge clk);
        new_game = 1;
        @(negedge clk); new_game = 0;
        exp_winner = 0;
        check("newgame_busy", busy, 0);
        check("newgame_winner", winner, exp_winner);
        check("newgame_mem_rd", mem_rd, 0);
        count_done(45, dn);
        check("newgame_no_done", dn, 0);
        @(negedge clk); new_game = 1; start = 1; row = 7; col = 7;
        @(negedge clk); new_game = 0; start = 0;
        check("newgame_start_busy", busy, 0);
        count_done(45, dn);
        check("newgame_start_no_done", dn, 0);

        pulse_new_game();
        play_round(0);
        repeat (3) @(negedge clk);
        check("draw_sticky", draw, 1);
        pulse_new_game();
        check("draw_cleared", draw, 0);
        play_round(1);
        check("final_win_winner", winner, exp_winner);
        check("final_win_draw", draw, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/win_check_scheduler.md
# win_check_scheduler

Sequences the five-in-a-row check after every placed stone. Given the coordinate and colour of the last move, it walks the board memory along the four line directions (horizontal, vertical, diagonal, anti-diagonal) and counts consecutive stones of that colour. It reports win, no-win or draw to the game-state FSM in the top level. It is the single owner of the board-memory read port while a check is in progress.

## Interface
Parameters:
- BOARD_N, 15: board edge length (cells per row/column).
- WIN_LEN, 5: run length that wins.
- COORD_W, 4: row/col width, must satisfy 2^COORD_W >= BOARD_N.
- ADDR_W, 8: board address width, must satisfy 2^ADDR_W >= BOARD_N*BOARD_N.

Ports:
- CLOCK_50  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to check the move at row/col; ignored unless idle.
- row  in  COORD_W  row of placed stone; sampled with start.
- col  in  COORD_W  column of placed stone; sampled with start.
- player  in  1  0 = black (cell code 2'b01), 1 = white (cell code 2'b10); sampled with start.
- new_game  in  1  synchronous clear of move count and result flags; aborts any scan.
- mem_addr  out  ADDR_W  board read address, row*BOARD_N+col.
- mem_rd  out  1  read strobe; board returns data one cycle later.
- mem_data  in  2  cell code: 00 empty, 01 black, 10 white, 11 treated as empty.
- busy  out  1  scan in progress.
- done  out  1  one-cycle pulse, result valid.
- win  out  1  valid with done: placed stone completes a run >= WIN_LEN.
- draw  out  1  sticky: board full without win; cleared by new_game/reset.
- winner  out  1  sticky player of the winning move; meaningful once a win occurred.

## Operation
- States: IDLE, SCAN, FINISH. Reset values: state IDLE, busy 0, done 0, win 0, draw 0, winner 0, mem_rd 0, mem_addr 0, move count 0.
- IDLE: start=1 latches row/col/player, increments move count, goes to SCAN.
- SCAN: for direction d = H(0,+1), V(+1,0), D(+1,+1), A(+1,-1) in order, step k = -(WIN_LEN-1) .. +(WIN_LEN-1), issuing one position per cycle (36 positions at defaults).
- Position (row+k*dr, col+k*dc) out of board: mem_rd=0, issue tagged invalid (counts as mismatch).
- Tagged issue also carries first-of-direction flag; run counter clears on that flag before evaluating.
- Evaluate one cycle after issue: match (mem_data == player code) -> run+1, else run=0. run reaching WIN_LEN -> win found; stop issuing, go FINISH.
- After the last issue's evaluation with no win, go FINISH.
- FINISH: done=1 for one cycle, win set; win -> winner=player; no win and move count == BOARD_N*BOARD_N -> draw=1. Return to IDLE.
- Win on the final cell is a win, not a draw.
- Board memory must already hold the new stone when start is asserted; the placed cell is read like any other.
- Arithmetic: coordinates in signed COORD_W+1 bits; address computed only for in-bounds positions. The move counter saturates at BOARD_N*BOARD_N.
- start while busy: ignored, no count increment.
- new_game: any state -> IDLE; clears move count, draw, winner; no done pulse. new_game and start in the same cycle: new_game wins, start dropped.
- reset mid-scan: immediate return to reset values; no done.

## Timing
- start sampled at edge E0. First issue in cycle E0+1; busy high from E0+1 until FINISH exits.
- Full no-win scan: issues cycles 1..36, last evaluation cycle 37, done cycle 38 (latency 38 at defaults; generally 4*(2*WIN_LEN-1)+2).
- Early win: evaluation in cycle t reaches WIN_LEN -> done in cycle t+1; no further mem_rd after cycle t.
- win valid only in the done cycle; draw and winner hold until cleared.
- Earliest next start accepted the cycle after done.

## Structure
- Shared package gomoku_pkg: cell codes (EMPTY, BLACK, WHITE), BOARD_N default, direction delta constants, scheduler state enum.
- One sub-module: win_scan_stepper. Takes base row/col, direction index and step k; returns in_bounds and mem_addr; combinational plus a one-stage tag register.
- Scheduler top holds the FSM, run counter, move counter and result flags.

## Test plan
- Black stones at (7,3)..(7,7), start at (7,7) player 0 -> done at cycle 38 or earlier, win=1, winner=0.
- Black at (7,3)..(7,6) plus white (7,7), start (7,6) -> done at cycle 38, win=0, draw=0.
- White diagonal (0,0)..(4,4), start (0,0) player 1 -> out-of-bound issues have mem_rd=0; win=1 during the D direction; no mem_rd after the detecting evaluation.
- White anti-diagonal (0,14)..(4,10), start (4,10) player 1 -> win=1. Start pulsed again mid-scan -> ignored, move count unchanged.
- reset low at cycle 10 of a scan -> all outputs at reset values immediately, no done. new_game mid-scan -> IDLE, no done.
- 225 accepted no-win moves (BOARD_N=15) -> done with draw=1 on the last. Last move completing a run -> win=1, draw=0.
